// File: rtl/input_conditioner.sv
// Per-channel synchroniser, debouncer and edge detector for raw async inputs.
// Emits a clean level plus registered single-cycle rise/fall/selected pulses.
module input_conditioner #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = raw_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Count only while the synchronised input disagrees with the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = sync[i];
        rise_d[i]  = sync[i];
        fall_d[i]  = ~sync[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    pulse_d = rise_d;
    if (EDGE_MODE == 1) begin
      pulse_d = fall_d;
    end else if (EDGE_MODE == 2) begin
      pulse_d = rise_d | fall_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign pulse_o = pulse_q;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Per-channel conditioning front end for raw asynchronous inputs such as buttons, external status lines and trigger pins. Each channel is synchronised into the clk domain, debounced, and edge-detected. The block outputs a clean level plus single-cycle edge pulses. The pulses drive the team's pulse-stretching stage for LED and status indication.

Parameters:
WIDTH, 1, number of independent channels.
SYNC_STAGES, 2, flip-flops in each synchroniser chain; legal values are 2 or more.
DEBOUNCE_CYCLES, 1000, consecutive cycles a new synchronised value must persist before it is accepted; legal values are 1 or more.
EDGE_MODE, 0, which edge produces pulse_o: 0 = rising, 1 = falling, 2 = both.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
raw_i  input  WIDTH  asynchronous raw inputs, one per channel.
level_o  output  WIDTH  debounced, synchronised level per channel.
rise_o  output  WIDTH  one-cycle pulse when level_o goes 0->1.
fall_o  output  WIDTH  one-cycle pulse when level_o goes 1->0.
pulse_o  output  WIDTH  one-cycle pulse on the edge(s) selected by EDGE_MODE.

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk. While reset is high, all synchroniser flops, debounce counters, level_o, rise_o, fall_o and pulse_o are 0.
- Channels are fully independent; no cross-channel interaction.
- Synchroniser: raw_i[i] passes through SYNC_STAGES flops. The last flop is sync[i]. Its only purpose is metastability containment; no logic taps intermediate stages.
- Debounce counter: cnt[i] has width clog2(DEBOUNCE_CYCLES+1). It is evaluated at each clk edge:
  - If sync[i] == level_o[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: level_o[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Any return of sync[i] to level_o[i] before acceptance clears the count. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches level_o.
- Edge pulses: rise_o[i], fall_o[i] and pulse_o[i] are registered. They assert on the same edge that level_o[i] changes and stay high for exactly one cycle.
- Pulse spacing: two pulses on a channel are separated by at least DEBOUNCE_CYCLES cycles.
- pulse_o selection: EDGE_MODE 0 gives pulse_o = rise_o; 1 gives fall_o; 2 gives rise_o | fall_o.
- Latency: raw_i is a step held stable and sampled at edge k. level_o and the pulse change at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, raw sampled at edge 1 gives sync at edge 2, cnt=1,2,3 at edges 3,4,5, and the flip plus pulse at edge 6.
- DEBOUNCE_CYCLES=1: level_o follows sync one cycle late with no filtering.
- Input high through reset: level_o starts at 0 after reset release. A rising edge is therefore reported SYNC_STAGES+DEBOUNCE_CYCLES cycles after release. This is intended, so that pulse consumers see the initial state.
- Reset mid-debounce: the count is discarded and no pulse is emitted. Qualification restarts from 0 after release.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- No combinational path from raw_i to any output.

Test Plan:
- Clean step: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, raw_i[0] 0->1 sampled at edge 1 -> level_o[0]=1 and rise_o[0]=pulse_o[0]=1 at edge 6 only; pulse low at edge 7; fall_o stays 0.
- Glitch rejection: DEBOUNCE_CYCLES=4, raw high for 3 cycles then low -> level_o, rise_o and pulse_o stay 0 throughout. Then raw high for 4 cycles -> rise pulse exactly once.
- Bounce: raw toggles 1,0,1,1,0,1,1,1,1 (one value per cycle), DEBOUNCE_CYCLES=4 -> single rise pulse, 2+4-1 edges after the start of the final run of four 1s; counter verified to clear on each 0.
- EDGE_MODE=2, WIDTH=2: ch0 rises and ch1 falls (ch1 previously settled high) in the same cycle -> rise_o=01, fall_o=10 and pulse_o=11 on the same edge.
- Async reset mid-count: raw high, reset asserted between clock edges when cnt=2 -> all outputs 0 immediately. After release with raw still high -> rise after the full SYNC_STAGES+DEBOUNCE_CYCLES latency.
- Input high across reset: raw_i=1 before and during reset -> level_o=0 at release, then one rise pulse at release+SYNC_STAGES+DEBOUNCE_CYCLES.
